// File: rtl/flexcim_pkg.sv
// Shared types and constants for the FlexCIM array sequencer: controller states,
// command op encodings and the column-strobe layout helpers.
package flexcim_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_COMPUTE = 2'd1;

  // How the strobe expander fills the per-macro column vectors.
  typedef enum logic [1:0] {
    STROBE_OFF     = 2'd0,
    STROBE_ONE_HOT = 2'd1,
    STROBE_ALL     = 2'd2
  } strobe_mode_t;

  localparam int DEF_NUM_SUB_MACROS = 4;
  localparam int DEF_NUM_COLS       = 32;

  // Bit offset of macro m inside a flattened column vector.
  function automatic int strobe_base(input int macro, input int num_cols);
    return macro * num_cols;
  endfunction

endpackage

// File: rtl/flexcim_col_strobe.sv
// Combinational expansion of column pointer, macro mask and mode into the
// flattened sel_cols / write_en vectors (macro m at [m*NUM_COLS +: NUM_COLS]).
module flexcim_col_strobe
  import flexcim_pkg::*;
#(
  parameter int NUM_SUB_MACROS = DEF_NUM_SUB_MACROS,
  parameter int NUM_COLS       = DEF_NUM_COLS,
  parameter int COL_W          = $clog2(NUM_COLS)
) (
  input  logic [COL_W-1:0]                   col_ptr,
  input  logic [NUM_SUB_MACROS-1:0]          mask,
  input  strobe_mode_t                       mode,
  output logic [NUM_SUB_MACROS*NUM_COLS-1:0] sel_cols,
  output logic [NUM_SUB_MACROS*NUM_COLS-1:0] write_en
);

  logic [NUM_COLS-1:0] col_onehot;

  // One-hot decode of the current write column.
  always_comb begin
    col_onehot          = '0;
    col_onehot[col_ptr] = 1'b1;
  end

  // Per-macro fill: one column for writes, every column for compute.
  always_comb begin
    sel_cols = '0;
    write_en = '0;
    for (int m = 0; m < NUM_SUB_MACROS; m++) begin
      if (mask[m]) begin
        case (mode)
          STROBE_ONE_HOT: begin
            sel_cols[strobe_base(m, NUM_COLS) +: NUM_COLS] = col_onehot;
            write_en[strobe_base(m, NUM_COLS) +: NUM_COLS] = col_onehot;
          end
          STROBE_ALL: begin
            sel_cols[strobe_base(m, NUM_COLS) +: NUM_COLS] = {NUM_COLS{1'b1}};
            write_en[strobe_base(m, NUM_COLS) +: NUM_COLS] = {NUM_COLS{1'b0}};
          end
          default: begin
            sel_cols[strobe_base(m, NUM_COLS) +: NUM_COLS] = {NUM_COLS{1'b0}};
            write_en[strobe_base(m, NUM_COLS) +: NUM_COLS] = {NUM_COLS{1'b0}};
          end
        endcase
      end else begin
        sel_cols[strobe_base(m, NUM_COLS) +: NUM_COLS] = {NUM_COLS{1'b0}};
        write_en[strobe_base(m, NUM_COLS) +: NUM_COLS] = {NUM_COLS{1'b0}};
      end
    end
  end

endmodule

// File: rtl/flexcim_ctrl.sv
// FlexCIM array sequencer: walks WRITE/COMPUTE commands beat by beat and drives
// en/sel_cols/write_en/i_valid. Define FLEXCIM_CTRL_PERF_EN for busy/stall counters.
module flexcim_ctrl
  import flexcim_pkg::*;
#(
  parameter int NUM_SUB_MACROS = 4,
  parameter int NUM_ROWS       = 32,
  parameter int NUM_COLS       = 32,
  parameter int LEN_W          = 16,
  parameter int DRAIN_CYCLES   = 8,
  parameter int COL_W          = $clog2(NUM_COLS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_op,
  input  logic [NUM_SUB_MACROS-1:0]          cmd_mask,
  input  logic [COL_W-1:0]                   cmd_col_start,
  input  logic [LEN_W-1:0]                   cmd_len,
  input  logic                               src_valid,
  output logic                               src_ready,
  output logic [NUM_SUB_MACROS-1:0]          en,
  output logic [NUM_SUB_MACROS*NUM_COLS-1:0] sel_cols,
  output logic [NUM_SUB_MACROS*NUM_COLS-1:0] write_en,
  output logic [NUM_ROWS-1:0]                i_valid,
  output logic                               busy,
  output logic                               done,
  output logic                               cmd_err
`ifdef FLEXCIM_CTRL_PERF_EN
  ,
  output logic [31:0]                        perf_busy_cycles,
  output logic [31:0]                        perf_stall_cycles
`endif
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int SEL_W   = NUM_SUB_MACROS * NUM_COLS;
  localparam logic [LEN_W-1:0]   LAST_BEAT  = LEN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);

  ctrl_state_t                state_r;
  ctrl_state_t                state_nxt;
  logic [NUM_SUB_MACROS-1:0]  mask_r;
  logic [COL_W-1:0]           col_ptr_r;
  logic [LEN_W-1:0]           beats_left_r;
  logic [DRAIN_W-1:0]         drain_cnt_r;

  logic                       accept_s;
  logic                       beat_s;
  logic                       op_reserved_s;
  logic [NUM_SUB_MACROS-1:0]  mask_s;
  strobe_mode_t               strobe_mode_s;
  logic [SEL_W-1:0]           strobe_sel_s;
  logic [SEL_W-1:0]           strobe_we_s;

  assign cmd_ready     = (state_r == IDLE);
  assign busy          = (state_r != IDLE);
  assign src_ready     = ((state_r == WRITE) || (state_r == COMPUTE)) && (beats_left_r != '0);
  assign accept_s      = cmd_valid & cmd_ready;
  assign beat_s        = src_valid & src_ready;
  assign op_reserved_s = (cmd_op != OP_WRITE) && (cmd_op != OP_COMPUTE);
  // While idle the command port is the only source of the mask for the entry cycle.
  assign mask_s        = (state_r == IDLE) ? cmd_mask : mask_r;

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !op_reserved_s) begin
          if (cmd_len == '0) begin
            state_nxt = DONE;
          end else if (cmd_op == OP_WRITE) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = COMPUTE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (beat_s && (beats_left_r == LAST_BEAT)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WRITE;
        end
      end
      COMPUTE: begin
        if (beat_s && (beats_left_r == LAST_BEAT)) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = COMPUTE;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe mode for the value registered at the coming edge.
  always_comb begin
    strobe_mode_s = STROBE_OFF;
    if ((state_r == WRITE) && beat_s) begin
      strobe_mode_s = STROBE_ONE_HOT;
    end else if ((state_nxt == COMPUTE) || (state_nxt == DRAIN)) begin
      strobe_mode_s = STROBE_ALL;
    end else begin
      strobe_mode_s = STROBE_OFF;
    end
  end

  flexcim_col_strobe #(
    .NUM_SUB_MACROS (NUM_SUB_MACROS),
    .NUM_COLS       (NUM_COLS),
    .COL_W          (COL_W)
  ) u_col_strobe (
    .col_ptr  (col_ptr_r),
    .mask     (mask_s),
    .mode     (strobe_mode_s),
    .sel_cols (strobe_sel_s),
    .write_en (strobe_we_s)
  );

  // State register and command/beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      mask_r       <= '0;
      col_ptr_r    <= '0;
      beats_left_r <= '0;
      drain_cnt_r  <= '0;
    end else begin
      state_r     <= state_nxt;
      drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + DRAIN_W'(1) : '0;
      if (accept_s) begin
        mask_r       <= cmd_mask;
        col_ptr_r    <= cmd_col_start;
        beats_left_r <= cmd_len;
      end else if (beat_s) begin
        beats_left_r <= beats_left_r - LAST_BEAT;
        if (state_r == WRITE) begin
          col_ptr_r <= (col_ptr_r == COL_LAST) ? '0 : col_ptr_r + COL_W'(1);
        end
      end
    end
  end

  // Registered array controls and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= '0;
      sel_cols <= '0;
      write_en <= '0;
      i_valid  <= '0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      en       <= ((state_nxt == COMPUTE) || (state_nxt == DRAIN)) ? mask_s : '0;
      sel_cols <= strobe_sel_s;
      write_en <= strobe_we_s;
      i_valid  <= ((state_r == COMPUTE) && beat_s) ? {NUM_ROWS{1'b1}} : {NUM_ROWS{1'b0}};
      done     <= (state_nxt == DONE);
      cmd_err  <= accept_s && op_reserved_s;
    end
  end

`ifdef FLEXCIM_CTRL_PERF_EN
  logic stall_s;
  assign stall_s = src_ready & ~src_valid;

  // Saturating busy and source-stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles  <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (stall_s && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_flexcim_ctrl.sv
// Self-checking bench for flexcim_ctrl: directed table, reset abort, random commands
// checked cycle by cycle against a beat-list model. Honors FLEXCIM_CTRL_PERF_EN.
module tb_flexcim_ctrl;

  localparam int NSM  = 4;
  localparam int NR   = 32;
  localparam int NC   = 32;
  localparam int LW   = 16;
  localparam int D    = 8;
  localparam int SW   = NSM * NC;
  localparam int MAXC = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [NSM-1:0]  cmd_mask;
  logic [4:0]      cmd_col_start;
  logic [LW-1:0]   cmd_len;
  logic            src_valid;
  logic            src_ready;
  logic [NSM-1:0]  en;
  logic [SW-1:0]   sel_cols;
  logic [SW-1:0]   write_en;
  logic [NR-1:0]   i_valid;
  logic            busy;
  logic            done;
  logic            cmd_err;
`ifdef FLEXCIM_CTRL_PERF_EN
  logic [31:0]     perf_busy_cycles;
  logic [31:0]     perf_stall_cycles;
`endif

  flexcim_ctrl #(
    .NUM_SUB_MACROS (NSM), .NUM_ROWS (NR), .NUM_COLS (NC),
    .LEN_W (LW), .DRAIN_CYCLES (D)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
    .cmd_mask (cmd_mask), .cmd_col_start (cmd_col_start), .cmd_len (cmd_len),
    .src_valid (src_valid), .src_ready (src_ready),
    .en (en), .sel_cols (sel_cols), .write_en (write_en), .i_valid (i_valid),
    .busy (busy), .done (done), .cmd_err (cmd_err)
`ifdef FLEXCIM_CTRL_PERF_EN
    , .perf_busy_cycles (perf_busy_cycles), .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected per-cycle trace; cycle 0 is the cycle the command is offered.
  logic [SW-1:0]  exp_sel   [MAXC];
  logic [SW-1:0]  exp_we    [MAXC];
  logic [NSM-1:0] exp_en    [MAXC];
  logic [NR-1:0]  exp_iv    [MAXC];
  bit             exp_done  [MAXC];
  bit             exp_busy  [MAXC];
  bit             exp_sready[MAXC];
  bit             exp_cready[MAXC];
  bit             exp_err   [MAXC];
  bit             vpat      [MAXC];
  int             last_cyc;
  int             model_done;

  typedef struct {
    logic [1:0]     op;
    logic [NSM-1:0] mask;
    logic [4:0]     cs;
    int             len;
    logic [15:0]    pat;      // bit c-1 = src_valid in cycle c; later cycles valid
    int             exp_done; // cycle of the done pulse, -1 for none
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [SW-1:0] act,
                     input logic [SW-1:0] exp, input int cyc);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_pat_fixed(input logic [15:0] pat);
    for (int c = 0; c < MAXC; c++) begin
      if (c >= 1 && c <= 16) vpat[c] = pat[c-1];
      else vpat[c] = 1'b1;
    end
  endtask

  task automatic set_pat_rand(input int stall_pct);
    for (int c = 0; c < MAXC; c++) begin
      if (c > 150) vpat[c] = 1'b1;
      else vpat[c] = ($urandom_range(99, 0) >= stall_pct);
    end
  endtask

  // Model: list the beat cycles, then place each effect at its cycle.
  task automatic build_model(input logic [1:0] op, input logic [NSM-1:0] mask,
                             input logic [4:0] cs, input int len);
    int beats[$];
    int c;
    int lastb;
    for (int i = 0; i < MAXC; i++) begin
      exp_sel[i] = '0; exp_we[i] = '0; exp_en[i] = '0; exp_iv[i] = '0;
      exp_done[i] = 0; exp_busy[i] = 0; exp_sready[i] = 0;
      exp_cready[i] = 0; exp_err[i] = 0;
    end
    exp_cready[0] = 1;
    if (op > 2'd1) begin
      exp_err[1] = 1;
      exp_cready[1] = 1;
      exp_cready[2] = 1;
      last_cyc = 2;
      model_done = -1;
      return;
    end
    if (len == 0) begin
      model_done = 1;
    end else begin
      c = 1;
      while (beats.size() < len && c < MAXC - D - 4) begin
        exp_sready[c] = 1;
        if (vpat[c]) beats.push_back(c);
        c++;
      end
      lastb = beats[beats.size()-1];
      if (op == 2'd0) begin
        model_done = lastb + 1;
        for (int k = 0; k < beats.size(); k++) begin
          for (int m = 0; m < NSM; m++) begin
            if (mask[m]) begin
              exp_we[beats[k]+1][m*NC + (int'(cs) + k) % NC]  = 1'b1;
              exp_sel[beats[k]+1][m*NC + (int'(cs) + k) % NC] = 1'b1;
            end
          end
        end
      end else begin
        model_done = lastb + D + 1;
        for (int k = 0; k < beats.size(); k++) exp_iv[beats[k]+1] = '1;
        for (int cc = 1; cc < model_done; cc++) begin
          exp_en[cc] = mask;
          for (int m = 0; m < NSM; m++)
            if (mask[m]) exp_sel[cc][m*NC +: NC] = '1;
        end
      end
    end
    for (int cc = 1; cc <= model_done; cc++) exp_busy[cc] = 1;
    exp_done[model_done] = 1;
    exp_cready[model_done+1] = 1;
    last_cyc = model_done + 1;
  endtask

  // Offer one command, drive vpat, compare every output each cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [NSM-1:0] mask,
                         input logic [4:0] cs, input int len, output int done_seen);
    build_model(op, mask, cs, len);
    done_seen = -1;
    for (int c = 0; c <= last_cyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask;
        cmd_col_start = cs; cmd_len = LW'(len); src_valid = 1'b0;
      end else begin
        // Commands offered while busy must be ignored.
        cmd_valid = (op < 2'd2) && (c <= model_done) && ($urandom_range(1, 0) == 1);
        cmd_op = 2'($urandom); cmd_mask = 4'($urandom);
        cmd_col_start = 5'($urandom); cmd_len = 16'($urandom_range(9, 1));
        src_valid = vpat[c];
      end
      @(negedge clk);
      chk("write_en",  write_en,       exp_we[c],             c);
      chk("sel_cols",  sel_cols,       exp_sel[c],            c);
      chk("en",        SW'(en),        SW'(exp_en[c]),        c);
      chk("i_valid",   SW'(i_valid),   SW'(exp_iv[c]),        c);
      chk("done",      SW'(done),      SW'(exp_done[c]),      c);
      chk("busy",      SW'(busy),      SW'(exp_busy[c]),      c);
      chk("src_ready", SW'(src_ready), SW'(exp_sready[c]),    c);
      chk("cmd_ready", SW'(cmd_ready), SW'(exp_cready[c]),    c);
      chk("cmd_err",   SW'(cmd_err),   SW'(exp_err[c]),       c);
      if (done === 1'b1 && done_seen < 0) done_seen = c;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; src_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int dseen;
    vecs[0] = '{2'd0, 4'b0010, 5'd30, 4,  16'hFFFF, 5};
    vecs[1] = '{2'd1, 4'b1111, 5'd0,  3,  16'hFFFD, 13};
    vecs[2] = '{2'd2, 4'b1111, 5'd0,  3,  16'hFFFF, -1};
    vecs[3] = '{2'd3, 4'b0101, 5'd7,  2,  16'hFFFF, -1};
    vecs[4] = '{2'd1, 4'b1111, 5'd0,  0,  16'hFFFF, 1};
    vecs[5] = '{2'd0, 4'b1111, 5'd4,  0,  16'hFFFF, 1};
    vecs[6] = '{2'd1, 4'b0000, 5'd0,  2,  16'hFFFF, 11};
    vecs[7] = '{2'd0, 4'b1001, 5'd0,  33, 16'hFFFF, 34};
    vecs[8] = '{2'd0, 4'b1111, 5'd31, 2,  16'hFFF0, 7};
    vecs[9] = '{2'd1, 4'b0101, 5'd0,  1,  16'hFFFF, 10};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_mask = '0;
    cmd_col_start = '0; cmd_len = '0; src_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", SW'(cmd_ready), SW'(1'b1), 0);
    chk("rst_busy",      SW'(busy),      SW'(1'b0), 0);
    chk("rst_en",        SW'(en),        '0,        0);
    chk("rst_sel",       sel_cols,       '0,        0);
    chk("rst_iv",        SW'(i_valid),   '0,        0);
    chk("rst_done",      SW'(done),      SW'(1'b0), 0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      set_pat_fixed(vecs[v].pat);
      run_cmd(vecs[v].op, vecs[v].mask, vecs[v].cs, vecs[v].len, dseen);
      chk($sformatf("done_cycle_vec%0d", v), SW'(dseen), SW'(vecs[v].exp_done), v);
    end

    // Reset during the second compute beat aborts with no done.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_mask = 4'hF; cmd_len = 16'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0; src_valid = 1'b1;
    @(posedge clk); #2;
    chk("pre_rst_en", SW'(en), SW'(4'hF), 2);
    rst = 1'b1; #1;
    chk("arst_en",        SW'(en),        '0,        2);
    chk("arst_sel",       sel_cols,       '0,        2);
    chk("arst_iv",        SW'(i_valid),   '0,        2);
    chk("arst_busy",      SW'(busy),      SW'(1'b0), 2);
    chk("arst_cmd_ready", SW'(cmd_ready), SW'(1'b1), 2);
    chk("arst_src_ready", SW'(src_ready), SW'(1'b0), 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("arst_no_done", SW'(done), SW'(1'b0), i);
    end
    src_valid = 1'b0; rst = 1'b0;
    set_pat_fixed(16'hFFFF);
    run_cmd(2'd0, 4'b0010, 5'd30, 4, dseen);
    chk("post_rst_done_cycle", SW'(dseen), SW'(5), 0);

    // Random commands with random source stalls.
    for (int r = 0; r < 30; r++) begin
      int sel;
      logic [1:0] op;
      sel = $urandom_range(9, 0);
      op  = (sel < 4) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
      set_pat_rand($urandom_range(60, 0));
      run_cmd(op, 4'($urandom), 5'($urandom), $urandom_range(20, 0), dseen);
    end

`ifdef FLEXCIM_CTRL_PERF_EN
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_pat_fixed(16'hFFF9);
    run_cmd(2'd0, 4'hF, 5'd0, 3, dseen);
    chk("perf_stall", SW'(perf_stall_cycles), SW'(32'd2), 0);
    chk("perf_busy",  SW'(perf_busy_cycles),  SW'(32'd6), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/flexcim_ctrl.md
Name: flexcim_ctrl

Overview:
Sequencer for the FlexCIM array. It accepts weight-write and compute commands over a valid/ready port and walks the column or input-vector count. It drives the array's en, sel_cols, write_en and i_valid controls, and signals completion after a fixed drain window. It sits between the tile scheduler (command source plus input/weight streamer) and the flexcim top.

Parameters:
NUM_SUB_MACROS, 4, sub-macros in the array
NUM_ROWS, 32, rows per sub-macro (i_valid width)
NUM_COLS, 32, columns per sub-macro
LEN_W, 16, width of command length field
DRAIN_CYCLES, 8, cycles en stays high after last compute beat (distribution + macro + merge latency)
COL_W, $clog2(NUM_COLS), column index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller accepts command (IDLE only)
cmd_op  in  2  0=WRITE, 1=COMPUTE, 2/3 reserved
cmd_mask  in  NUM_SUB_MACROS  target sub-macros
cmd_col_start  in  COL_W  first column (WRITE only)
cmd_len  in  LEN_W  beats: columns (WRITE) or input vectors (COMPUTE)
src_valid  in  1  streamer has a beat
src_ready  out  1  controller consumes beat
en  out  NUM_SUB_MACROS  sub-macro enable
sel_cols  out  NUM_SUB_MACROS*NUM_COLS  column select, macro m at [m*NUM_COLS +: NUM_COLS]
write_en  out  NUM_SUB_MACROS*NUM_COLS  column write strobe, same layout
i_valid  out  NUM_ROWS  row input valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at command completion
cmd_err  out  1  one-cycle pulse on reserved op

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 except cmd_ready=1; counters cleared; reset mid-command aborts with no done.
- States: IDLE, WRITE, COMPUTE, DRAIN, DONE.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready; latch op, mask, col_start, len.
  - op 0 -> WRITE; op 1 -> COMPUTE; op 2/3 -> cmd_err pulse next cycle, stay IDLE.
  - cmd_len=0 -> DONE directly; no strobes issued.
- WRITE: src_ready=1 while beats_left>0. On beat (src_valid&src_ready), registered next cycle:
  - write_en and sel_cols = one-hot column col_ptr for every macro m with mask[m]=1, else 0.
  - col_ptr increments modulo NUM_COLS and wraps 31->0; beats_left decrements.
  - No beat -> write_en=0, sel_cols=0 that cycle; stalls are unbounded.
  - After last beat -> DONE. en=0 throughout WRITE.
- COMPUTE: en=mask registered on entry and held through DRAIN; sel_cols = all ones for masked macros; write_en=0.
  - On beat: i_valid=all ones next cycle, else 0. beats_left decrements.
  - After last beat -> DRAIN.
- DRAIN: src_ready=0; i_valid=0; counts DRAIN_CYCLES cycles -> DONE.
- DONE: done=1 for one cycle; en, sel_cols, write_en, i_valid cleared; -> IDLE. Next cmd_ready is the cycle after DONE.
- Latency: beat accepted in cycle t -> strobe visible at t+1. Command accepted at t with len N (N>0, no stalls):
  - WRITE: done at t+N+1.
  - COMPUTE: done at t+N+DRAIN_CYCLES+1.
- Arithmetic: beats_left is LEN_W bits and only ever decrements from a nonzero value, so no wrap. Drain counter is $clog2(DRAIN_CYCLES+1) bits.
- cmd_mask=0: command runs its full timing; no strobes or en asserted.

Optional Feature:
FLEXCIM_CTRL_PERF_EN:
- Defined: adds outputs perf_busy_cycles[31:0] (cycles busy=1) and perf_stall_cycles[31:0] (cycles in WRITE/COMPUTE with src_ready=1 and src_valid=0). Both saturate at 2^32-1 and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package flexcim_pkg holds:
  - state enum (IDLE, WRITE, COMPUTE, DRAIN, DONE)
  - op encodings OP_WRITE=2'd0 and OP_COMPUTE=2'd1
  - column-strobe layout helper constants
- Sub-module flexcim_col_strobe (combinational): expands col_ptr, mask and mode into sel_cols/write_en vectors. The FSM and counters stay in flexcim_ctrl.

Test Plan:
- WRITE, mask=4'b0010, col_start=30, len=4, src_valid constant -> write_en bits 62,63,32,33 one per cycle; done at accept+5.
- COMPUTE, mask=4'b1111, len=3, src_valid pattern 1,0,1,1 -> i_valid=all ones on 3 cycles with one gap; en=4'hF held until done; done at last beat+DRAIN_CYCLES+1.
- cmd_op=2 -> cmd_err one pulse; busy stays 0; cmd_ready stays 1.
- cmd_len=0 COMPUTE -> no en/i_valid; done one cycle after DONE entry (accept+1).
- Assert rst during COMPUTE beat 2 -> all outputs 0 asynchronously; no done; next command executes normally.
- PERF build: 3-beat WRITE with 2 stall cycles -> perf_stall_cycles=2; perf_busy_cycles=6.
